// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
//  Module      : icache_dm_if
//  Description : Datapath fetch port and memory-controller read port of the
//                direct-mapped instruction cache, bundled as one interface.
//                'slave' is the cache view; 'master' is the environment view
//                (datapath plus memory controller).
//  Revision    : 1.0  initial release
// ============================================================================
interface icache_dm_if;
    // Datapath side
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    // Memory-controller side
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module      : icache_dm
//  Description : Direct-mapped, one-word-per-frame instruction cache.
//                Hits are combinational in IDLE; a miss latches the address
//                and fetches one word from the memory controller in FETCH.
//                Flush invalidates every frame, deferred until a fill ends.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_dm #(
    parameter int SETS = 16,
    parameter int IDXW = $clog2(SETS)
) (
    input  logic       CLK,
    input  logic       nRST,
    icache_dm_if.slave bus
);

    localparam int TAGW = 32 - IDXW - 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t          state_q;
    logic [SETS-1:0] valid_q;
    logic [TAGW-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS];
    logic [31:0]     miss_addr_q;
    logic            flush_pend_q;
    logic            iren_q;

    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic [IDXW-1:0] miss_idx;
    logic [TAGW-1:0] miss_tag;
    logic            lookup_hit;
    logic            hit;
    logic            fill_en;

    // Address split: byte offset ignored, index selects the frame, tag compared.
    assign req_idx  = bus.imemaddr[IDXW+1:2];
    assign req_tag  = bus.imemaddr[31:IDXW+2];
    assign miss_idx = miss_addr_q[IDXW+1:2];
    assign miss_tag = miss_addr_q[31:IDXW+2];

    // Raw tag lookup; a cleared valid bit masks unreset tag/data contents.
    assign lookup_hit = valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    // A hit is only reported in IDLE and never while a deferred flush is due.
    assign hit = (state_q == IDLE) & bus.imemREN & ~flush_pend_q & lookup_hit;

    // The memory word is accepted in the FETCH cycle where iwait drops.
    assign fill_en = (state_q == FETCH) & ~bus.iwait;

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data_q[req_idx] : 32'h0;
    assign bus.iREN     = iren_q;
    assign bus.iaddr    = iren_q ? miss_addr_q : 32'h0;

    // Control FSM: miss detection, fill completion, valid bits and flush handling.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_addr_q  <= 32'h0;
            flush_pend_q <= 1'b0;
            iren_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_pend_q || bus.flush) begin
                        // Invalidate everything; never start a miss in this cycle.
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (bus.imemREN && !lookup_hit) begin
                        miss_addr_q <= bus.imemaddr;
                        state_q     <= FETCH;
                        iren_q      <= 1'b1;
                    end
                end
                FETCH: begin
                    // A flush seen mid-fill is remembered and applied in IDLE,
                    // so it also wipes the frame being filled now.
                    if (bus.flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (!bus.iwait) begin
                        valid_q[miss_idx] <= 1'b1;
                        state_q           <= IDLE;
                        iren_q            <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    iren_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag/data storage is not reset; written only when a fill completes.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= bus.iload;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_dm
//  Description : Testbench for icache_dm with a behavioural cache model,
//                directed scenarios and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_dm;

    localparam int SETS = 16;
    localparam int IDXW = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    icache_dm_if bus ();

    icache_dm #(
        .SETS (SETS),
        .IDXW (IDXW)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents seen by the memory controller.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    assign bus.iload = memfn(bus.iaddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: which word address each frame holds, whether a
    // fetch is outstanding, and whether a flush is owed.
    // ------------------------------------------------------------------
    bit          m_valid [SETS];
    logic [31:0] m_addr  [SETS];
    bit          m_busy;
    bit          m_fpend;
    logic [31:0] m_miss;
    logic [31:0] m_a;
    int          m_ix;
    int          m_mi;
    bit          m_lk;
    bit          m_eh;

    always @(negedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
            m_busy  = 1'b0;
            m_fpend = 1'b0;
            m_miss  = 32'h0;
            chk("rst_ihit",     32'(bus.ihit), 32'h0);
            chk("rst_imemload", bus.imemload,  32'h0);
            chk("rst_iREN",     32'(bus.iREN), 32'h0);
            chk("rst_iaddr",    bus.iaddr,     32'h0);
        end else begin
            m_a  = bus.imemaddr;
            m_ix = int'((m_a >> 2) % SETS);
            m_lk = m_valid[m_ix] && (m_addr[m_ix][31:2] == m_a[31:2]);
            m_eh = !m_busy && !m_fpend && bus.imemREN && m_lk;
            chk("model_ihit",     32'(bus.ihit), 32'(m_eh));
            chk("model_imemload", bus.imemload,  m_eh ? memfn(m_addr[m_ix]) : 32'h0);
            chk("model_iREN",     32'(bus.iREN), 32'(m_busy));
            chk("model_iaddr",    bus.iaddr,     m_busy ? m_miss : 32'h0);
            if (m_busy) begin
                if (bus.flush) m_fpend = 1'b1;
                if (!bus.iwait) begin
                    m_mi          = int'((m_miss >> 2) % SETS);
                    m_valid[m_mi] = 1'b1;
                    m_addr[m_mi]  = m_miss;
                    m_busy        = 1'b0;
                end
            end else if (m_fpend || bus.flush) begin
                for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
                m_fpend = 1'b0;
            end else if (bus.imemREN && !m_lk) begin
                m_busy = 1'b1;
                m_miss = m_a;
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Miss on addr, hold iwait high for 'waits' FETCH cycles, then expect the hit.
    task automatic do_miss(input logic [31:0] addr, input int waits);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        #1 chk("miss_ihit", 32'(bus.ihit), 32'h0);
        step();
        #1 chk("miss_iREN", 32'(bus.iREN), 32'h1);
        chk("miss_iaddr", bus.iaddr, addr);
        repeat (waits) step();
        bus.iwait = 1'b0;
        step();
        bus.iwait = 1'b1;
        #1 chk("fill_ihit", 32'(bus.ihit), 32'h1);
        chk("fill_imemload", bus.imemload, memfn(addr));
        step();
    endtask

    task automatic do_hit(input logic [31:0] addr);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        #1 chk("hit_ihit", 32'(bus.ihit), 32'h1);
        chk("hit_imemload", bus.imemload, memfn(addr));
        chk("hit_iREN", 32'(bus.iREN), 32'h0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.flush    = 1'b0;
        bus.iwait    = 1'b1;
        nRST         = 1'b0;
        repeat (2) step();
        chk("reset_iREN",     32'(bus.iREN), 32'h0);
        chk("reset_iaddr",    bus.iaddr,     32'h0);
        chk("reset_ihit",     32'(bus.ihit), 32'h0);
        chk("reset_imemload", bus.imemload,  32'h0);
        nRST = 1'b1;

        // Cold miss at 0x40: four FETCH cycles, hit on the fifth.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0040;
        bus.iwait    = 1'b1;
        #1 chk("cold_ihit", 32'(bus.ihit), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            bus.iwait = (i == 4) ? 1'b0 : 1'b1;
            #1 chk("cold_iREN", 32'(bus.iREN), 32'h1);
            chk("cold_iaddr", bus.iaddr, 32'h0000_0040);
        end
        step();
        bus.iwait = 1'b1;
        #1 chk("cold_fill_ihit", 32'(bus.ihit), 32'h1);
        chk("cold_fill_data", bus.imemload, 32'h8C22_0004);
        chk("cold_fill_iREN", 32'(bus.iREN), 32'h0);
        step();

        // Re-request hits immediately.
        do_hit(32'h0000_0040);

        // Conflict on index 0.
        do_miss(32'h0000_0080, 1);
        do_miss(32'h0000_0040, 0);

        // Address changes while fetching 0x44.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0044;
        #1 chk("chg_ihit", 32'(bus.ihit), 32'h0);
        step();
        bus.imemaddr = 32'h0000_0048;
        #1 chk("chg_iaddr_latched", bus.iaddr, 32'h0000_0044);
        bus.iwait = 1'b0;
        step();
        bus.iwait = 1'b1;
        #1 chk("chg_new_miss", 32'(bus.ihit), 32'h0);
        step();
        #1 chk("chg_iaddr_new", bus.iaddr, 32'h0000_0048);
        bus.iwait = 1'b0;
        step();
        bus.iwait = 1'b1;
        #1 chk("chg_fill_ihit", 32'(bus.ihit), 32'h1);
        chk("chg_fill_data", bus.imemload, memfn(32'h0000_0048));
        step();
        do_hit(32'h0000_0044);

        // Flush while fetching 0x4C.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_004C;
        #1 chk("fl_ihit", 32'(bus.ihit), 32'h0);
        step();
        bus.flush = 1'b1;
        #1 chk("fl_iREN", 32'(bus.iREN), 32'h1);
        step();
        bus.flush = 1'b0;
        bus.iwait = 1'b0;
        step();
        bus.iwait = 1'b1;
        #1 chk("fl_pending_ihit", 32'(bus.ihit), 32'h0);
        step();
        #1 chk("fl_no_miss_started", 32'(bus.iREN), 32'h0);
        do_miss(32'h0000_004C, 0);
        do_miss(32'h0000_0040, 1);

        // Reset in the middle of fetching 0x50.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0050;
        #1 chk("rstf_ihit", 32'(bus.ihit), 32'h0);
        step();
        #1 chk("rstf_iREN_before", 32'(bus.iREN), 32'h1);
        nRST = 1'b0;
        #1 chk("rstf_iREN_drop", 32'(bus.iREN), 32'h0);
        chk("rstf_iaddr_drop", bus.iaddr, 32'h0);
        step();
        step();
        nRST = 1'b1;
        do_miss(32'h0000_0050, 2);

        // Flush in IDLE: same-cycle hit still visible, gone afterwards.
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0050;
        bus.flush    = 1'b1;
        #1 chk("idle_flush_same_cycle_ihit", 32'(bus.ihit), 32'h1);
        step();
        bus.flush = 1'b0;
        do_miss(32'h0000_0050, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            nRST          = ($urandom_range(0, 299) != 0);
            bus.imemREN   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                bus.imemaddr = (32'($urandom_range(0, 3)) << 6)
                             | (32'($urandom_range(0, 15)) << 2)
                             | (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'h0);
            end
            bus.iwait = ($urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 39) == 0);
            step();
        end
        nRST        = 1'b1;
        bus.imemREN = 1'b0;
        bus.flush   = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter: SETS, 16, number of direct-mapped frames; power of two, 2..64.
REQ-002 Parameter: IDXW, $clog2(SETS), index width.
REQ-003 Port: CLK  input  1  clock, rising-edge.
REQ-004 Port: nRST  input  1  asynchronous, active-low reset.
REQ-005 Port: imemREN  input  1  datapath instruction read request.
REQ-006 Port: imemaddr  input  32  datapath fetch byte address, word-aligned.
REQ-007 Port: ihit  output  1  requested word valid on imemload this cycle.
REQ-008 Port: imemload  output  32  instruction word returned to datapath.
REQ-009 Port: flush  input  1  single-cycle pulse; invalidate all frames.
REQ-010 Port: iREN  output  1  memory-controller read request.
REQ-011 Port: iaddr  output  32  memory-controller read address.
REQ-012 Port: iwait  input  1  memory-controller busy; 0 = iload valid this cycle.
REQ-013 Port: iload  input  32  memory-controller read data.

Function
REQ-014 Address split: [1:0] offset, ignored; [IDXW+1:2] index; [31:IDXW+2] tag.
REQ-015 Each frame holds valid bit, tag, 32-bit data word.
REQ-016 FSM states: IDLE, FETCH.
REQ-017 IDLE: ihit = imemREN & valid[idx] & (tag[idx] == addr tag), combinational, same cycle.
REQ-018 imemload = data[idx] while ihit = 1; 32'h0 otherwise.
REQ-019 IDLE & imemREN & not hit: latch imemaddr into miss register; next state FETCH; ihit = 0.
REQ-020 FETCH: iREN = 1; iaddr = latched miss address; ihit = 0; iREN = 0 and iaddr = 32'h0 in IDLE.
REQ-021 FETCH & iwait = 1: remain in FETCH; no frame change.
REQ-022 FETCH & iwait = 0: write frame at latched index (valid = 1, latched tag, data = iload); next state IDLE.
REQ-023 Miss latency: miss detected cycle 0, iREN from cycle 1; if iwait = 0 in cycle k, ihit = 1 in cycle k+1 when imemaddr is unchanged.
REQ-024 imemaddr change or imemREN deassertion during FETCH: the fill completes to the latched address; the new address is evaluated in IDLE afterwards.
REQ-025 The datapath holds imemaddr stable until ihit; the cache does not depend on this for correctness.
REQ-026 A fill to an occupied frame overwrites it (no write-back; instruction side is read-only).
REQ-027 flush in IDLE: all valid bits cleared at the next edge; ihit in that same cycle still reflects the pre-flush state.
REQ-028 flush in FETCH: set a flush-pending flag; the fill completes, then all valid bits are cleared on the edge after entering IDLE, including the frame just filled.
REQ-029 While flush-pending = 1 in IDLE, ihit = 0 and no new miss is started.
REQ-030 No miss is started in the same cycle a flush is applied.

Reset
REQ-031 nRST low: state = IDLE, all valid bits = 0, flush-pending = 0, miss register = 0; immediate, asynchronous.
REQ-032 Outputs during/after reset: ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
REQ-033 Tag/data arrays need not be reset; valid = 0 masks them.
REQ-034 Reset asserted during FETCH aborts the fill; no frame is written; iREN drops immediately.

Verification
REQ-035 Cold miss: after reset, imemREN = 1, imemaddr = 0x00000040, iwait = 1 for 3 cycles then 0 with iload = 0x8C220004 -> iREN = 1 and iaddr = 0x40 for 4 cycles; ihit = 1 with imemload = 0x8C220004 the following cycle.
REQ-036 Hit: re-request 0x40 -> ihit = 1 the same cycle; iREN stays 0.
REQ-037 Conflict: fill 0x40, then request 0x00000080 (same index 0, different tag) -> miss, fill 0x80; a subsequent request to 0x40 misses again.
REQ-038 Address change mid-fill: request 0x44, switch imemaddr to 0x48 during FETCH -> frame 1 is filled for 0x44, then a miss and fetch at 0x48; request 0x44 afterwards hits.
REQ-039 Flush during FETCH: pulse flush while fetching 0x4C -> the fill completes, then all frames are invalid; requests to 0x40 and 0x4C both miss.
REQ-040 Reset mid-fill: nRST low during FETCH for 0x50 -> iREN = 0 immediately; after release, 0x50 misses.
